// File: rtl/mvau_deadlock_pkg.sv
// Shared types and helpers for the MVAU deadlock reporter.
// Optional macro MVAU_DEADLOCK_TIMESTAMP_EN is consumed by the top module.
package mvau_deadlock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    REPORT = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int EVT_W = 8;

  // Counter only has to reach PERSIST-1, so clog2(PERSIST) bits suffice.
  function automatic int persist_cnt_w(input int persist);
    return (persist <= 2) ? 1 : $clog2(persist);
  endfunction

endpackage

// File: rtl/mvau_deadlock_persist_cnt.sv
// Persistence counter: load-to-one, increment, clear, terminal count at PERSIST-1.
module mvau_deadlock_persist_cnt
  import mvau_deadlock_pkg::*;
#(
  parameter int PERSIST = 16,
  parameter int CNT_W   = persist_cnt_w(PERSIST)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_load,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(PERSIST - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CNT_W'(1);
    end else if (i_inc) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/mvau_deadlock_reporter.sv
// Declares a deadlock once block persists for PERSIST cycles and latches one report per event.
// Define MVAU_DEADLOCK_TIMESTAMP_EN to build the free-running timestamp behind report_ts.
module mvau_deadlock_reporter
  import mvau_deadlock_pkg::*;
#(
  parameter int N_AXIS  = 3,
  parameter int N_IDLE  = 2,
  parameter int PERSIST = 16,
  parameter int TS_W    = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              block,
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic [N_IDLE-1:0] inst_idle_sigs,
  input  logic              report_ack,
  output logic              report_valid,
  output logic [N_AXIS-1:0] report_axis,
  output logic [N_IDLE-1:0] report_idle,
  output logic [TS_W-1:0]   report_ts,
  output logic              deadlock_irq,
  output logic [EVT_W-1:0]  event_count
);

  localparam int CNT_W = persist_cnt_w(PERSIST);

  state_t r_state;
  state_t w_state_next;
  logic   w_load;
  logic   w_inc;
  logic   w_clr;
  logic   w_detect;
  logic   w_tc;

  logic [N_AXIS-1:0] r_report_axis;
  logic [N_IDLE-1:0] r_report_idle;
  logic              r_irq;
  logic [EVT_W-1:0]  r_event_count;

  mvau_deadlock_persist_cnt #(
    .PERSIST (PERSIST),
    .CNT_W   (CNT_W)
  ) u_persist_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_inc   (w_inc),
    .i_clr   (w_clr),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_inc        = 1'b0;
    w_clr        = 1'b0;
    w_detect     = 1'b0;
    case (r_state)
      IDLE: begin
        if (block) begin
          if (PERSIST == 1) begin
            w_state_next = REPORT;
            w_detect     = 1'b1;
          end else begin
            w_state_next = ARM;
            w_load       = 1'b1;
          end
        end
      end
      ARM: begin
        if (!block) begin
          w_state_next = IDLE;
          w_clr        = 1'b1;
        end else if (w_tc) begin
          w_state_next = REPORT;
          w_detect     = 1'b1;
          w_clr        = 1'b1;
        end else begin
          w_inc = 1'b1;
        end
      end
      REPORT: begin
        // Ack with block already gone goes straight back to IDLE.
        if (report_ack) begin
          w_state_next = block ? HOLD : IDLE;
        end
      end
      HOLD: begin
        if (!block) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_report_axis <= '0;
      r_report_idle <= '0;
      r_irq         <= 1'b0;
      r_event_count <= '0;
    end else begin
      r_irq <= w_detect;
      if (w_detect) begin
        r_report_axis <= axis_block_sigs;
        r_report_idle <= inst_idle_sigs;
        if (r_event_count != {EVT_W{1'b1}}) begin
          r_event_count <= r_event_count + EVT_W'(1);
        end
      end
    end
  end

`ifdef MVAU_DEADLOCK_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;
  logic [TS_W-1:0] r_report_ts;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ts        <= '0;
      r_report_ts <= '0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
      if (w_detect) begin
        r_report_ts <= r_ts;
      end
    end
  end

  assign report_ts = r_report_ts;
`else
  assign report_ts = '0;
`endif

  assign report_valid = (r_state == REPORT);
  assign report_axis  = r_report_axis;
  assign report_idle  = r_report_idle;
  assign deadlock_irq = r_irq;
  assign event_count  = r_event_count;

endmodule

// File: tb/tb_mvau_deadlock_reporter.sv
// Self-checking bench: run-length reference model compared every cycle, plus directed literal checks.
module tb_mvau_deadlock_reporter;

  localparam int N_AXIS  = 3;
  localparam int N_IDLE  = 2;
  localparam int PERSIST = 16;
  localparam int TS_W    = 32;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              block = 1'b0;
  logic [N_AXIS-1:0] axis_block_sigs = '0;
  logic [N_IDLE-1:0] inst_idle_sigs = '0;
  logic              report_ack = 1'b0;
  logic              report_valid;
  logic [N_AXIS-1:0] report_axis;
  logic [N_IDLE-1:0] report_idle;
  logic [TS_W-1:0]   report_ts;
  logic              deadlock_irq;
  logic [7:0]        event_count;

  int n_checks = 0;
  int n_fail   = 0;

  mvau_deadlock_reporter #(
    .N_AXIS  (N_AXIS),
    .N_IDLE  (N_IDLE),
    .PERSIST (PERSIST),
    .TS_W    (TS_W)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .block           (block),
    .axis_block_sigs (axis_block_sigs),
    .inst_idle_sigs  (inst_idle_sigs),
    .report_ack      (report_ack),
    .report_valid    (report_valid),
    .report_axis     (report_axis),
    .report_idle     (report_idle),
    .report_ts       (report_ts),
    .deadlock_irq    (deadlock_irq),
    .event_count     (event_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts consecutive block cycles while armed; pending/waiting flags
  // express "one report per persisting deadlock".
  bit              m_pending = 0;
  bit              m_wait    = 0;
  int              m_run     = 0;
  bit              m_irq     = 0;
  int              m_cnt     = 0;
  logic [N_AXIS-1:0] m_axis  = '0;
  logic [N_IDLE-1:0] m_idle  = '0;
  logic [TS_W-1:0]   m_ts    = '0;
  longint          m_edges   = 0;

  initial begin
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        m_pending = 0; m_wait = 0; m_run = 0; m_irq = 0; m_cnt = 0;
        m_axis = '0; m_idle = '0; m_ts = '0; m_edges = 0;
      end else begin
        m_edges++;
        m_irq = 0;
        if (m_pending) begin
          if (report_ack) begin
            m_pending = 0;
            m_wait    = block;
          end
        end else if (m_wait) begin
          if (!block) m_wait = 0;
        end else begin
          m_run = block ? m_run + 1 : 0;
          if (m_run == PERSIST) begin
            m_run     = 0;
            m_pending = 1;
            m_irq     = 1;
            m_cnt     = (m_cnt < 255) ? m_cnt + 1 : 255;
            m_axis    = axis_block_sigs;
            m_idle    = inst_idle_sigs;
`ifdef MVAU_DEADLOCK_TIMESTAMP_EN
            m_ts      = TS_W'(m_edges - 1);
`else
            m_ts      = '0;
`endif
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    chk("valid", 64'(report_valid), 64'(m_pending));
    chk("irq",   64'(deadlock_irq), 64'(m_irq));
    chk("evt",   64'(event_count),  64'(m_cnt));
    chk("axis",  64'(report_axis),  64'(m_axis));
    chk("idle",  64'(report_idle),  64'(m_idle));
    chk("ts",    64'(report_ts),    64'(m_ts));
  end

  // Drive inputs sampled by the next edge, then return just after that edge.
  task automatic cyc(input logic b, input logic a);
    block      = b;
    report_ack = a;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    block = 1'b0;
    report_ack = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("rst_evt", 64'(event_count), 64'd0);
    chk("rst_valid", 64'(report_valid), 64'd0);

    // 15 cycles of block is one short of a deadlock
    repeat (15) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("short_valid", 64'(report_valid), 64'd0);
    chk("short_evt", 64'(event_count), 64'd0);

    // 16 cycles declares a deadlock with the snapshot of the final cycle
    axis_block_sigs = 3'b101;
    inst_idle_sigs  = 2'b10;
    repeat (15) cyc(1'b1, 1'b0);
    chk("pre_valid", 64'(report_valid), 64'd0);
    cyc(1'b1, 1'b0);
    chk("det_valid", 64'(report_valid), 64'd1);
    chk("det_axis", 64'(report_axis), 64'h5);
    chk("det_idle", 64'(report_idle), 64'h2);
    chk("det_irq", 64'(deadlock_irq), 64'd1);
    chk("det_evt", 64'(event_count), 64'd1);
    axis_block_sigs = 3'b010;
    cyc(1'b1, 1'b0);
    chk("irq_once", 64'(deadlock_irq), 64'd0);
    chk("snap_stable", 64'(report_axis), 64'h5);
    cyc(1'b0, 1'b1);
    chk("ack_drop_valid", 64'(report_valid), 64'd0);

    // Persisting deadlock yields a single report until block drops
    do_reset();
    repeat (16) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    chk("hold_valid", 64'(report_valid), 64'd0);
    repeat (100) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    chk("hold_evt", 64'(event_count), 64'd1);
    chk("hold_valid2", 64'(report_valid), 64'd0);
    cyc(1'b0, 1'b0);
    repeat (16) cyc(1'b1, 1'b0);
    chk("second_valid", 64'(report_valid), 64'd1);
    chk("second_evt", 64'(event_count), 64'd2);
    cyc(1'b0, 1'b1);

    // Async reset in REPORT wipes everything immediately
    repeat (16) cyc(1'b1, 1'b0);
    chk("pre_rst_valid", 64'(report_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 64'(report_valid), 64'd0);
    chk("arst_evt", 64'(event_count), 64'd0);
    chk("arst_axis", 64'(report_axis), 64'd0);
    chk("arst_irq", 64'(deadlock_irq), 64'd0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (3) begin
      cyc(1'b0, 1'b0);
      chk("post_rst_irq", 64'(deadlock_irq), 64'd0);
    end

    // Detection at edge 1000 after reset
    do_reset();
    repeat (984) cyc(1'b0, 1'b0);
    repeat (16) cyc(1'b1, 1'b0);
    chk("ts_valid", 64'(report_valid), 64'd1);
`ifdef MVAU_DEADLOCK_TIMESTAMP_EN
    chk("ts_1000", 64'(report_ts), 64'd999);
`else
    chk("ts_1000", 64'(report_ts), 64'd0);
`endif
    cyc(1'b0, 1'b1);

    // Saturation after 300 events
    do_reset();
    for (int i = 0; i < 300; i++) begin
      repeat (PERSIST) cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b1);
    end
    chk("sat_evt", 64'(event_count), 64'd255);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      axis_block_sigs = N_AXIS'($urandom);
      inst_idle_sigs  = N_IDLE'($urandom);
      cyc(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
